cr_clint_mhart_regs: RTL and testbench

- Multi-hart CLINT register block: bus decode, per-hart MSIP/MTIMECMP storage, a shared 64-bit MTIME counter and interrupt generation in one module.
- Sits behind the TCIPIF slave port and drives the per-hart software and timer interrupt lines into the cores.
- Generalises the single-hart decode to HART_NUM harts.
- Adds registered read data with a 1-cycle completion, a writable mtime counter and compare logic.

---
 rtl/cr_clint_mhart_regs.sv | 127 ++++++++++++
 tb/tb_cr_clint_mhart_regs.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cr_clint_mhart_regs.sv
// CLINT register block for HART_NUM harts: bus decode, per-hart MSIP/MTIMECMP,
// a shared 64-bit MTIME counter and software/timer interrupt generation.
module cr_clint_mhart_regs #(
   parameter int          HART_NUM     = 1,
   parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic                forever_cpuclk,
   input  logic                cpurst_b,
   input  logic                tcipif_clint_sel,
   input  logic                tcipif_clint_write,
   input  logic [15:0]         tcipif_clint_addr,
   input  logic [31:0]         tcipif_clint_wdata,
   input  logic                sysio_clint_mtime_tick,
   output logic                clint_tcipif_cmplt,
   output logic [31:0]         clint_tcipif_rdata,
   output logic [HART_NUM-1:0] clint_core_ms_int,
   output logic [HART_NUM-1:0] clint_core_mt_int,
   output logic [63:0]         clint_mtime_value
);

   logic [HART_NUM-1:0] msip;
   logic [63:0]         mtimecmp [HART_NUM];
   logic [63:0]         mtime;

   logic                cmplt_p1;
   logic [31:0]         rdata_p1;
   logic [HART_NUM-1:0] mt_int_p1;

   logic                wr_en;
   logic [31:0]         rd_val;
   logic [HART_NUM-1:0] msip_we;
   logic [HART_NUM-1:0] cmp_lo_we;
   logic [HART_NUM-1:0] cmp_hi_we;
   logic                mtime_lo_we;
   logic                mtime_hi_we;

   assign wr_en = tcipif_clint_sel & tcipif_clint_write;

   // Address decode and read mux; unmatched offsets read 0 and drop writes.
   always_comb begin
      rd_val      = 32'h0;
      msip_we     = '0;
      cmp_lo_we   = '0;
      cmp_hi_we   = '0;
      mtime_lo_we = 1'b0;
      mtime_hi_we = 1'b0;
      for (int h = 0; h < HART_NUM; h++) begin
         if (tcipif_clint_addr == 16'(4 * h)) begin
            rd_val     = {31'h0, msip[h]};
            msip_we[h] = wr_en;
         end
         if (tcipif_clint_addr == 16'(32'h4000 + 8 * h)) begin
            rd_val       = mtimecmp[h][31:0];
            cmp_lo_we[h] = wr_en;
         end
         if (tcipif_clint_addr == 16'(32'h4004 + 8 * h)) begin
            rd_val       = mtimecmp[h][63:32];
            cmp_hi_we[h] = wr_en;
         end
      end
      if (tcipif_clint_addr == 16'hBFF8) begin
         rd_val      = mtime[31:0];
         mtime_lo_we = wr_en;
      end
      if (tcipif_clint_addr == 16'hBFFC) begin
         rd_val      = mtime[63:32];
         mtime_hi_we = wr_en;
      end
   end

   // Stage p1: bus completion and registered read data
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         cmplt_p1 <= 1'b0;
         rdata_p1 <= 32'h0;
      end else begin
         cmplt_p1 <= tcipif_clint_sel;
         if (tcipif_clint_sel)
            rdata_p1 <= tcipif_clint_write ? 32'h0 : rd_val;
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         msip <= '0;
         for (int h = 0; h < HART_NUM; h++)
            mtimecmp[h] <= MTIMECMP_RST;
      end else begin
         for (int h = 0; h < HART_NUM; h++) begin
            if (msip_we[h])
               msip[h] <= tcipif_clint_wdata[0];
            if (cmp_lo_we[h])
               mtimecmp[h][31:0] <= tcipif_clint_wdata;
            if (cmp_hi_we[h])
               mtimecmp[h][63:32] <= tcipif_clint_wdata;
         end
      end
   end

   // A software write to either half takes priority over the tick increment.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b)
         mtime <= 64'h0;
      else if (mtime_lo_we)
         mtime[31:0] <= tcipif_clint_wdata;
      else if (mtime_hi_we)
         mtime[63:32] <= tcipif_clint_wdata;
      else if (sysio_clint_mtime_tick)
         mtime <= mtime + 64'h1;
   end

   // Stage p1: timer compare on current register values
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b)
         mt_int_p1 <= '0;
      else
         for (int h = 0; h < HART_NUM; h++)
            mt_int_p1[h] <= (mtime >= mtimecmp[h]);
   end

   assign clint_tcipif_cmplt = cmplt_p1;
   assign clint_tcipif_rdata = rdata_p1;
   assign clint_core_ms_int  = msip;
   assign clint_core_mt_int  = mt_int_p1;
   assign clint_mtime_value  = mtime;

endmodule

// File: tb/tb_cr_clint_mhart_regs.sv
// Directed bench for cr_clint_mhart_regs with four harts.
module tb_cr_clint_mhart_regs;

   localparam int HN = 4;

   logic          clk;
   logic          rst_n;
   logic          sel;
   logic          write;
   logic [15:0]   addr;
   logic [31:0]   wdata;
   logic          tick;
   logic          cmplt;
   logic [31:0]   rdata;
   logic [HN-1:0] ms_int;
   logic [HN-1:0] mt_int;
   logic [63:0]   mtime;

   int total = 0;
   int bad   = 0;

   cr_clint_mhart_regs #(
      .HART_NUM     (HN),
      .MTIMECMP_RST (64'hFFFF_FFFF_FFFF_FFFF)
   ) dut (
      .forever_cpuclk         (clk),
      .cpurst_b               (rst_n),
      .tcipif_clint_sel       (sel),
      .tcipif_clint_write     (write),
      .tcipif_clint_addr      (addr),
      .tcipif_clint_wdata     (wdata),
      .sysio_clint_mtime_tick (tick),
      .clint_tcipif_cmplt     (cmplt),
      .clint_tcipif_rdata     (rdata),
      .clint_core_ms_int      (ms_int),
      .clint_core_mt_int      (mt_int),
      .clint_mtime_value      (mtime)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the next negedge, after the sel cycle's edge.
   task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] d);
      sel   = 1'b1;
      write = wr;
      addr  = a;
      wdata = d;
      @(negedge clk);
      sel   = 1'b0;
      write = 1'b0;
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      sel   = 1'b0;
      write = 1'b0;
      addr  = 16'h0;
      wdata = 32'h0;
      tick  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_cmplt", 64'(cmplt), 64'h0);
      check("rst_rdata", 64'(rdata), 64'h0);
      check("rst_ms", 64'(ms_int), 64'h0);
      check("rst_mt", 64'(mt_int), 64'h0);
      check("rst_mtime", mtime, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("idle_mt", 64'(mt_int), 64'h0);
      check("idle_cmplt", 64'(cmplt), 64'h0);

      // read MTIMECMP_HI[0]
      sel = 1'b1; write = 1'b0; addr = 16'h4004;
      #1 check("cmplt_in_sel", 64'(cmplt), 64'h0);
      @(negedge clk);
      sel = 1'b0;
      check("cmphi0_cmplt", 64'(cmplt), 64'h1);
      check("cmphi0_rdata", 64'(rdata), 64'hFFFF_FFFF);
      @(negedge clk);
      check("cmplt_drop", 64'(cmplt), 64'h0);
      check("rdata_hold", 64'(rdata), 64'hFFFF_FFFF);

      // MSIP on hart 3, back-to-back reads incl. unmapped
      xfer(1'b1, 16'h000C, 32'h1);
      check("msip3_wr_cmplt", 64'(cmplt), 64'h1);
      check("msip3_wr_rdata", 64'(rdata), 64'h0);
      check("msip3_ms", 64'(ms_int), 64'h8);
      xfer(1'b0, 16'h000C, 32'h0);
      check("msip3_rd_cmplt", 64'(cmplt), 64'h1);
      check("msip3_rd", 64'(rdata), 64'h1);
      xfer(1'b0, 16'h0010, 32'h0);
      check("unmap_cmplt", 64'(cmplt), 64'h1);
      check("unmap_rd", 64'(rdata), 64'h0);
      xfer(1'b1, 16'h0004, 32'hFFFF_FFFE);
      check("msip1_bit0_only", 64'(ms_int), 64'h8);
      xfer(1'b1, 16'h0004, 32'h3);
      check("msip1_set", 64'(ms_int), 64'hA);
      xfer(1'b0, 16'h0004, 32'h0);
      check("msip1_rd", 64'(rdata), 64'h1);
      xfer(1'b1, 16'h0014, 32'h1);
      check("unmap_wr_ms", 64'(ms_int), 64'hA);

      // MTIME carry across the 32-bit boundary
      xfer(1'b1, 16'hBFFC, 32'h0);
      xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFE);
      check("mtime_set", mtime, 64'h0000_0000_FFFF_FFFE);
      tick = 1'b1;
      repeat (3) @(negedge clk);
      tick = 1'b0;
      check("mtime_carry", mtime, 64'h0000_0001_0000_0001);
      xfer(1'b0, 16'hBFFC, 32'h0);
      check("mtime_hi_rd", 64'(rdata), 64'h1);

      // Timer interrupt on hart 1
      xfer(1'b1, 16'hBFFC, 32'h0);
      xfer(1'b1, 16'hBFF8, 32'h0);
      xfer(1'b1, 16'h400C, 32'h0);
      xfer(1'b1, 16'h4008, 32'h20);
      check("mt_before", 64'(mt_int), 64'h0);
      tick = 1'b1;
      n = 0;
      while (mtime != 64'h20 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("mtime_reach_20", mtime, 64'h20);
      check("mt_lag", 64'(mt_int), 64'h0);
      @(negedge clk);
      check("mt_assert", 64'(mt_int), 64'h2);
      xfer(1'b1, 16'h400C, 32'h1);
      check("mt_hold_after_wr", 64'(mt_int), 64'h2);
      @(negedge clk);
      check("mt_deassert", 64'(mt_int), 64'h0);

      // MTIME_LO write during tick, then back-to-back read
      xfer(1'b1, 16'hBFF8, 32'h5);
      check("mtime_wr_no_inc", mtime, 64'h5);
      xfer(1'b0, 16'hBFF8, 32'h0);
      check("mtime_lo_rd", 64'(rdata), 64'h5);
      check("mtime_inc_after", mtime, 64'h6);
      tick = 1'b0;

      // Reset in the cycle after a read's sel
      xfer(1'b0, 16'h4004, 32'h0);
      check("pre_rst_cmplt", 64'(cmplt), 64'h1);
      check("pre_rst_rdata", 64'(rdata), 64'hFFFF_FFFF);
      #2 rst_n = 1'b0;
      #1;
      check("arst_cmplt", 64'(cmplt), 64'h0);
      check("arst_rdata", 64'(rdata), 64'h0);
      check("arst_ms", 64'(ms_int), 64'h0);
      check("arst_mtime", mtime, 64'h0);
      check("arst_mt", 64'(mt_int), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      xfer(1'b0, 16'h400C, 32'h0);
      check("rst_cmphi1", 64'(rdata), 64'hFFFF_FFFF);
      xfer(1'b0, 16'h4008, 32'h0);
      check("rst_cmplo1", 64'(rdata), 64'hFFFF_FFFF);
      xfer(1'b0, 16'h000C, 32'h0);
      check("rst_msip3", 64'(rdata), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
